// File: rtl/onewire_pkg.sv
// Shared constants, default timing and FSM state type for the GH18B20 1-Wire responder.
package onewire_pkg;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  // Fixed scratchpad bytes 2..7: TH, TL, config (12-bit), reserved x3
  localparam logic [7:0] SpTh   = 8'h4B;
  localparam logic [7:0] SpTl   = 8'h46;
  localparam logic [7:0] SpCfg  = 8'h7F;
  localparam logic [7:0] SpRes0 = 8'hFF;
  localparam logic [7:0] SpRes1 = 8'h0C;
  localparam logic [7:0] SpRes2 = 8'h10;

  localparam logic [15:0] TempPor = 16'h0550;

  localparam int unsigned DefClkMhz    = 50;
  localparam int unsigned DefTRstlUs   = 480;
  localparam int unsigned DefTPdhUs    = 30;
  localparam int unsigned DefTPdlUs    = 120;
  localparam int unsigned DefTSampleUs = 30;
  localparam int unsigned DefTRdlUs    = 30;
  localparam int unsigned DefTConvUs   = 750000;

  typedef enum logic [2:0] {
    StIdle,
    StPresWait,
    StPresDrive,
    StRomRx,
    StFuncRx,
    StTx,
    StConvPoll
  } state_e;

  function automatic logic [7:0] sp_const(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd2:    r = SpTh;
      4'd3:    r = SpTl;
      4'd4:    r = SpCfg;
      4'd5:    r = SpRes0;
      4'd6:    r = SpRes1;
      4'd7:    r = SpRes2;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Bit-serial Dallas CRC-8 (x^8+x^5+x^4+1), LSB-first, init 0x00.
module onewire_crc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;
  assign fb = crc[0] ^ bit_in;

  // Reflected form of the polynomial is 0x8C; bit 7 is supplied by fb itself
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= {fb, crc[7:1]} ^ (fb ? 8'h0C : 8'h00);
    end
  end

endmodule

// File: rtl/gh18b20_slave.sv
// 1-Wire target emulating one GH18B20/DS18B20 sensor: presence, SKIP ROM, CONVERT T,
// READ SCRATCHPAD with CRC. Pad is built outside as dq = dq_oe ? 0 : z.
module gh18b20_slave
  import onewire_pkg::*;
#(
  parameter int unsigned CLK_MHZ     = DefClkMhz,
  parameter int unsigned T_RSTL_US   = DefTRstlUs,
  parameter int unsigned T_PDH_US    = DefTPdhUs,
  parameter int unsigned T_PDL_US    = DefTPdlUs,
  parameter int unsigned T_SAMPLE_US = DefTSampleUs,
  parameter int unsigned T_RDL_US    = DefTRdlUs,
  parameter int unsigned T_CONV_US   = DefTConvUs
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        dq_i,
  input  logic [15:0] temp_in,
  output logic        dq_oe,
  output logic        conv_busy,
  output logic        cmd_strobe,
  output logic [7:0]  cmd_code
);

  localparam int unsigned DivW  = $clog2(CLK_MHZ + 1);
  localparam int unsigned ConvW = $clog2(T_CONV_US + 1);

  logic             dq_s1_q, dq_s2_q, dq_prev_q;
  logic             fall, rise, fall_v;
  logic [DivW-1:0]  div_q;
  logic             tick;
  logic [9:0]       us_q;
  logic [ConvW-1:0] conv_cnt_q;
  logic             conv_busy_q;
  logic [15:0]      temp_q;
  logic [7:0]       crc;

  state_e      state_q, state_d;
  logic        dq_oe_q, dq_oe_d;
  logic        slot_q, slot_d;
  logic        arm_q, arm_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  code_q, code_d;
  logic        tmr_clr, conv_start, crc_clr, crc_en, crc_bit;
  logic [7:0]  rx_byte, sp_byte, tx_byte;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dq_s1_q   <= 1'b1;
      dq_s2_q   <= 1'b1;
      dq_prev_q <= 1'b1;
    end else begin
      dq_s1_q   <= dq_i;
      dq_s2_q   <= dq_s1_q;
      dq_prev_q <= dq_s2_q;
    end
  end

  assign fall   = dq_prev_q & ~dq_s2_q;
  assign rise   = ~dq_prev_q & dq_s2_q;
  // A fall while we pull the bus is our own echo
  assign fall_v = fall & ~dq_oe_q;

  assign tick = (div_q == DivW'(CLK_MHZ - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_q <= '0;
      us_q  <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (fall_v || tmr_clr) begin
        us_q <= '0;
      end else if (tick && (us_q != 10'h3FF)) begin
        us_q <= us_q + 10'd1;
      end
    end
  end

  // Conversion timer ignores bus resets; only a new CONVERT restarts it
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      conv_busy_q <= 1'b0;
      conv_cnt_q  <= '0;
      temp_q      <= TempPor;
    end else if (conv_start) begin
      conv_busy_q <= 1'b1;
      conv_cnt_q  <= '0;
    end else if (conv_busy_q && tick) begin
      if (conv_cnt_q == ConvW'(T_CONV_US)) begin
        conv_busy_q <= 1'b0;
        temp_q      <= temp_in;
      end else begin
        conv_cnt_q <= conv_cnt_q + 1'b1;
      end
    end
  end

  onewire_crc8 u_crc (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  // Next byte is fetched at its first bit so the CRC byte sees the final CRC value
  always_comb begin
    case (byte_cnt_q)
      4'd0:    sp_byte = temp_q[7:0];
      4'd1:    sp_byte = temp_q[15:8];
      4'd8:    sp_byte = crc;
      default: sp_byte = sp_const(byte_cnt_q);
    endcase
  end

  assign tx_byte = (bit_cnt_q == 3'd0) ? sp_byte : sr_q;
  assign rx_byte = {dq_s2_q, sr_q[7:1]};

  always_comb begin
    state_d    = state_q;
    dq_oe_d    = dq_oe_q;
    slot_d     = slot_q;
    arm_d      = arm_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    strobe_d   = 1'b0;
    code_d     = code_q;
    tmr_clr    = 1'b0;
    conv_start = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_bit    = 1'b0;

    if (dq_oe_q && (state_q != StPresDrive) && (us_q > 10'(T_RDL_US))) begin
      dq_oe_d = 1'b0;
    end
    if (!dq_s2_q && (us_q >= 10'(T_RSTL_US))) begin
      arm_d = 1'b1;
    end

    case (state_q)
      StPresWait: begin
        if (us_q > 10'(T_PDH_US)) begin
          state_d = StPresDrive;
          dq_oe_d = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      StPresDrive: begin
        if (us_q > 10'(T_PDL_US)) begin
          state_d   = StRomRx;
          dq_oe_d   = 1'b0;
          bit_cnt_d = 3'd0;
          slot_d    = 1'b0;
        end
      end
      StRomRx, StFuncRx: begin
        if (fall_v) begin
          slot_d = 1'b1;
        end else if (slot_q && (us_q > 10'(T_SAMPLE_US))) begin
          slot_d    = 1'b0;
          sr_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            strobe_d = 1'b1;
            code_d   = rx_byte;
            if (state_q == StRomRx) begin
              state_d = (rx_byte == CMD_SKIP_ROM) ? StFuncRx : StIdle;
            end else if (rx_byte == CMD_CONVERT) begin
              conv_start = 1'b1;
              state_d    = StConvPoll;
            end else if (rx_byte == CMD_READ_SP) begin
              crc_clr    = 1'b1;
              byte_cnt_d = 4'd0;
              state_d    = StTx;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StTx: begin
        if (fall_v) begin
          crc_en    = (byte_cnt_q != 4'd8);
          crc_bit   = tx_byte[0];
          dq_oe_d   = ~tx_byte[0];
          sr_d      = {1'b0, tx_byte[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd8) begin
              state_d = StIdle;
            end
          end
        end
      end
      StConvPoll: begin
        if (fall_v && conv_busy_q) begin
          dq_oe_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Completed bus reset overrides whatever the current state was doing
    if (rise && arm_q) begin
      state_d    = StPresWait;
      arm_d      = 1'b0;
      tmr_clr    = 1'b1;
      dq_oe_d    = 1'b0;
      slot_d     = 1'b0;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      dq_oe_q    <= 1'b0;
      slot_q     <= 1'b0;
      arm_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 4'd0;
      sr_q       <= 8'h00;
      strobe_q   <= 1'b0;
      code_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      dq_oe_q    <= dq_oe_d;
      slot_q     <= slot_d;
      arm_q      <= arm_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      strobe_q   <= strobe_d;
      code_q     <= code_d;
    end
  end

  assign dq_oe      = dq_oe_q;
  assign conv_busy  = conv_busy_q;
  assign cmd_strobe = strobe_q;
  assign cmd_code   = code_q;

endmodule

// File: doc/gh18b20_slave.md
# gh18b20_slave

Synthesizable 1-Wire responder that emulates a single GH18B20/DS18B20-class temperature sensor on the `dq` bus. It is the target-side counterpart of the `gh18b20` master driver: it answers the master's reset with a presence pulse, decodes ROM and function commands, runs a timed "conversion", and returns a 9-byte scratchpad with CRC. It is used as a synthesizable sensor stand-in, for board loopback and for FPGA-in-the-loop tests. The top level builds the open-drain pad as `dq = dq_oe ? 1'b0 : 1'bz`.

## Interface
- `CLK_MHZ`, 50: sys_clk frequency in MHz; sets the 1 µs tick divider.
- `T_RSTL_US`, 480: minimum bus-low time recognized as a master reset.
- `T_PDH_US`, 30: delay from reset release to the start of the presence pulse.
- `T_PDL_US`, 120: presence pulse width.
- `T_SAMPLE_US`, 30: write-slot sample point, measured after the falling edge.
- `T_RDL_US`, 30: time the block holds the bus low when sending a 0 bit.
- `T_CONV_US`, 750000: conversion time. Benches shorten this.
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  synchronous reset, active-high.
- `dq_i`  in  1  raw bus level, asynchronous.
- `temp_in`  in  16  two's-complement temperature in units of 1/16 °C; sampled when a conversion ends.
- `dq_oe`  out  1  1 = pull the bus low.
- `conv_busy`  out  1  high while a conversion is running.
- `cmd_strobe`  out  1  one-cycle pulse for each decoded command byte.
- `cmd_code`  out  8  last decoded command byte.

## Operation
- `dq_i` passes through a 2-flop synchronizer. A falling-edge detect on the synchronized level starts a slot.
- A free-running 1 µs tick drives a µs counter. The counter clears on every falling edge and saturates at 1023.
- **Reset detection.** Bus low for ≥ T_RSTL_US, in any state, arms a reset. The reset completes on the next rising edge, and the block enters PRES_WAIT. This applies mid-byte, during TX and during CONVERT.
- **States:** IDLE, PRES_WAIT, PRES_DRIVE, ROM_RX, FUNC_RX, TX, CONV_POLL.
  - IDLE: ignore all slots and wait for a reset.
  - PRES_WAIT: wait T_PDH_US, then go to PRES_DRIVE.
  - PRES_DRIVE: assert `dq_oe` for T_PDL_US, then go to ROM_RX.
  - ROM_RX: receive 8 bits. 0xCC goes to FUNC_RX. Any other byte goes to IDLE.
  - FUNC_RX: receive 8 bits.
    - 0x44 starts a conversion and goes to CONV_POLL.
    - 0xBE loads the scratchpad and goes to TX.
    - Any other byte goes to IDLE.
  - TX: send the scratchpad bytes LSB-first. After byte 8, go to IDLE. A reset can truncate the transfer at any bit.
  - CONV_POLL: each read slot returns 0 while `conv_busy` is high and 1 after it drops. The conversion timer keeps running even after a master reset.
- **Receive.** At T_SAMPLE_US after the falling edge, the synchronized level is the bit. Bits shift in LSB-first.
- **Transmit.** For a 0 bit, `dq_oe` rises on the cycle after the detected falling edge and is held for T_RDL_US. For a 1 bit, `dq_oe` is not asserted.
- **Conversion.** At the end of T_CONV_US, `temp_in` is latched into `temp_reg` and `conv_busy` falls. A 0x44 received while `conv_busy` is high restarts the timer.
- **Scratchpad, in byte order:** `temp_reg[7:0]`, `temp_reg[15:8]`, 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, CRC.
  - CRC is Dallas CRC-8 (x^8+x^5+x^4+1, init 0x00), computed bit-serially over bytes 0–7 as they are sent.
- `cmd_strobe` pulses for one cycle, with `cmd_code` updated, after the 8th bit of each ROM or function byte.

## Timing
- **Reset values:** state IDLE, `dq_oe` = 0, `conv_busy` = 0, `cmd_strobe` = 0, `cmd_code` = 0x00, `temp_reg` = 0x0550 (85 °C power-on value). Reset takes effect on the first sys_clk edge that sees `sys_rst` high.
- **Input latency:** 2 cycles of synchronizer plus 1 cycle of edge detect. All µs windows are accurate to −0/+1 µs plus 3 cycles.
- A falling edge that arrives while the block is driving `dq_oe` (presence or a read 0) is its own echo and is ignored.

## Structure
- `onewire_pkg` holds:
  - command constants CMD_SKIP_ROM = 0xCC, CMD_CONVERT = 0x44, CMD_READ_SP = 0xBE;
  - the scratchpad constant bytes;
  - the default timing values;
  - the state enum.
- One sub-module, `onewire_crc8`, is a bit-serial CRC with `clr`, `en` and `bit` inputs and a `crc[7:0]` output.

## Test plan
- **Power-on presence:** release `sys_rst`, master holds the bus low 500 µs then releases -> `dq_oe` rises 30 ± 1 µs after release and stays high 120 ± 1 µs.
- **Default readout:** reset, 0xCC, 0xBE, then 72 read slots -> bytes received are 0x50, 0x05, 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, CRC. The CRC-8 over all 9 bytes must equal 0x00.
- **Conversion:** set T_CONV_US = 100 and `temp_in` = 0xFE6F; send reset, 0xCC, 0x44; poll with read slots -> reads are 0 for about 100 µs, then 1. A following reset, 0xCC, 0xBE reads back bytes 0x6F, 0xFE.
- **Unsupported command:** reset, then 0x33 -> `cmd_code` = 0x33 and the block goes to IDLE. The next 16 slots see `dq_oe` = 0. After a new reset the block sends presence again.
- **Reset mid-transfer:** master holds the bus low 480 µs after the 13th read slot -> TX is abandoned and presence follows. A fresh read returns the full 9 bytes from byte 0.
- **Synchronous reset during PRES_DRIVE:** assert `sys_rst` -> `dq_oe` is 0 on the next sys_clk edge, and all outputs return to their reset values.
